// File: rtl/uart_flash_loader_if.sv
// Loader-side bundle: UART line and start pulse in, flash write port and status out.
interface uart_flash_loader_if #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ADDR_W = 11
);
  logic              rx;
  logic              start;
  logic              flash_en;
  logic [ADDR_W-1:0] flash_addr;
  logic [WIDTH-1:0]  flash_data;
  logic              busy;
  logic              done;
  logic              frame_err;
  logic              hdr_err;

  modport master (
    input  rx, start,
    output flash_en, flash_addr, flash_data, busy, done, frame_err, hdr_err
  );

  modport slave (
    output rx, start,
    input  flash_en, flash_addr, flash_data, busy, done, frame_err, hdr_err
  );
endinterface

// File: rtl/uart_flash_loader.sv
// UART boot loader: 16-bit little-endian word-count header, then little-endian 32-bit
// words written to the flash port one strobe per word; busy holds the core in reset.
module uart_flash_loader #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned ADDR_W       = 11
) (
  input logic               clk,
  input logic               rst,
  uart_flash_loader_if.master bus
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IdxW = ADDR_W + 1;
  localparam logic [CntW-1:0] BitEnd   = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfEnd  = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [16:0]     MaxWords = 17'(2 ** ADDR_W);

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
  typedef enum logic [1:0] {LdHdr0, LdHdr1, LdLoad, LdDone} ld_state_e;

  // ---------------- UART receiver ----------------
  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e       rx_state_q, rx_state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            byte_valid_q, byte_valid_d;
  logic            frame_err_q, frame_err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_prev_q    <= 1'b1;
      rx_state_q   <= RxIdle;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_meta_q    <= bus.rx;
      rx_sync_q    <= rx_meta_q;
      rx_prev_q    <= rx_sync_q;
      rx_state_q   <= rx_state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  always_comb begin
    rx_state_d   = rx_state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    frame_err_d  = frame_err_q;
    unique case (rx_state_q)
      RxIdle: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RxStart;
          cnt_d      = '0;
        end
      end
      RxStart: begin
        if (cnt_q == HalfEnd) begin
          cnt_d      = '0;
          bit_d      = '0;
          // A line already back high at mid start bit is a glitch, not a frame.
          rx_state_d = rx_sync_q ? RxIdle : RxData;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      RxData: begin
        if (cnt_q == BitEnd) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) rx_state_d = RxStop;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      RxStop: begin
        if (cnt_q == BitEnd) begin
          rx_state_d = RxIdle;
          if (rx_sync_q) byte_valid_d = 1'b1;
          else           frame_err_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  // ---------------- Loader ----------------
  ld_state_e         ld_state_q, ld_state_d;
  logic [15:0]       count_q, count_d;
  logic [1:0]        lane_q, lane_d;
  logic [WIDTH-1:0]  word_q, word_d;
  logic [IdxW-1:0]   widx_q, widx_d;
  logic              flash_en_q, flash_en_d;
  logic [ADDR_W-1:0] flash_addr_q, flash_addr_d;
  logic [WIDTH-1:0]  flash_data_q, flash_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              hdr_err_q, hdr_err_d;
  logic [15:0]       new_count;
  logic [WIDTH-1:0]  new_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_state_q   <= LdHdr0;
      count_q      <= '0;
      lane_q       <= '0;
      word_q       <= '0;
      widx_q       <= '0;
      flash_en_q   <= 1'b0;
      flash_addr_q <= '0;
      flash_data_q <= '0;
      busy_q       <= 1'b1;
      done_q       <= 1'b0;
      hdr_err_q    <= 1'b0;
    end else begin
      ld_state_q   <= ld_state_d;
      count_q      <= count_d;
      lane_q       <= lane_d;
      word_q       <= word_d;
      widx_q       <= widx_d;
      flash_en_q   <= flash_en_d;
      flash_addr_q <= flash_addr_d;
      flash_data_q <= flash_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      hdr_err_q    <= hdr_err_d;
    end
  end

  always_comb begin
    ld_state_d   = ld_state_q;
    count_d      = count_q;
    lane_d       = lane_q;
    word_d       = word_q;
    widx_d       = widx_q;
    flash_en_d   = 1'b0;
    flash_addr_d = flash_addr_q;
    flash_data_d = flash_data_q;
    busy_d       = busy_q;
    done_d       = done_q;
    hdr_err_d    = hdr_err_q;
    new_count    = {shift_q, count_q[7:0]};
    new_word     = word_q;
    new_word[8*lane_q +: 8] = shift_q;
    unique case (ld_state_q)
      LdHdr0: begin
        if (byte_valid_q) begin
          count_d[7:0] = shift_q;
          ld_state_d   = LdHdr1;
        end
      end
      LdHdr1: begin
        if (byte_valid_q) begin
          count_d = new_count;
          if (new_count == 16'd0) begin
            ld_state_d = LdDone;
            done_d     = 1'b1;
            busy_d     = 1'b0;
          end else if ({1'b0, new_count} > MaxWords) begin
            hdr_err_d  = 1'b1;
            ld_state_d = LdDone;
            done_d     = 1'b1;
            busy_d     = 1'b0;
          end else begin
            ld_state_d = LdLoad;
          end
        end
      end
      LdLoad: begin
        // widx has already advanced past the word being strobed this cycle.
        if (flash_en_q && (17'(widx_q) == {1'b0, count_q})) begin
          ld_state_d = LdDone;
          done_d     = 1'b1;
          busy_d     = 1'b0;
        end else if (byte_valid_q) begin
          if (lane_q == 2'd3) begin
            flash_en_d   = 1'b1;
            flash_data_d = new_word;
            flash_addr_d = widx_q[ADDR_W-1:0];
            widx_d       = widx_q + IdxW'(1);
            lane_d       = '0;
            word_d       = '0;
          end else begin
            word_d = new_word;
            lane_d = lane_q + 2'd1;
          end
        end
      end
      LdDone: begin
        if (bus.start) begin
          ld_state_d = LdHdr0;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          count_d    = '0;
          lane_d     = '0;
          word_d     = '0;
          widx_d     = '0;
        end
      end
      default: ld_state_d = LdHdr0;
    endcase
  end

  assign bus.flash_en   = flash_en_q;
  assign bus.flash_addr = flash_addr_q;
  assign bus.flash_data = flash_data_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.hdr_err    = hdr_err_q;

endmodule

// File: tb/tb_uart_flash_loader.sv
// Randomised and directed bench: expected flash writes are queued as stimulus is sent and
// a negedge monitor pops and compares them on every flash_en strobe.
module tb_uart_flash_loader;
  localparam int unsigned CLKS   = 4;
  localparam int unsigned ADDR_W = 11;
  localparam int unsigned WIDTH  = 32;

  typedef logic [7:0] bytes_t[$];
  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  data;
    bit                last;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_flash_loader_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

  uart_flash_loader #(
    .WIDTH(WIDTH),
    .CLKS_PER_BIT(CLKS),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  exp_t   exp_q[$];
  exp_t   e;
  int     n_tests = 0;
  int     n_fail = 0;
  int     n_strobes = 0;
  bit     prev_en = 1'b0;
  bit     pending_done = 1'b0;
  bytes_t bq;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst) begin
      prev_en = 1'b0;
      pending_done = 1'b0;
    end else begin
      if (pending_done) begin
        check("done_busy_after_last", {bus.done, bus.busy}, 2'b10);
        pending_done = 1'b0;
      end
      if (bus.flash_en) begin
        n_strobes++;
        check("no_back_to_back_strobe", prev_en, 1'b0);
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_strobe: got addr 0x%0h data 0x%0h, expected no strobe",
                   bus.flash_addr, bus.flash_data);
        end else begin
          e = exp_q.pop_front();
          check("flash_addr", bus.flash_addr, e.addr);
          check("flash_data", bus.flash_data, e.data);
          if (e.last) pending_done = 1'b1;
        end
      end
      prev_en = bus.flash_en;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    bus.rx = 1'b0;
    tick(CLKS);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      tick(CLKS);
    end
    bus.rx = stop_bit;
    tick(CLKS);
    bus.rx = 1'b1;
    tick(2 * CLKS);
  endtask

  task automatic send_all(input bytes_t bs);
    foreach (bs[i]) send_byte(bs[i], 1'b1);
  endtask

  task automatic push_exp(input int addr, input logic [31:0] data, input bit last);
    exp_t x;
    x.addr = ADDR_W'(addr);
    x.data = data;
    x.last = last;
    exp_q.push_back(x);
  endtask

  // Reference model: header count, then words assembled as b0 + b1*256 + ...
  task automatic model_image(input bytes_t bs);
    int cnt;
    logic [31:0] w;
    cnt = int'(bs[0]) + 256 * int'(bs[1]);
    for (int k = 0; k < cnt; k++) begin
      w = 32'(bs[2+4*k]) + (32'(bs[3+4*k]) << 8) + (32'(bs[4+4*k]) << 16)
        + (32'(bs[5+4*k]) << 24);
      push_exp(k, w, k == cnt - 1);
    end
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    tick(2);
  endtask

  task automatic wait_done(input string label);
    int i = 0;
    while (!bus.done && i < 3000) begin
      tick(1);
      i++;
    end
    tick(2);
    check({label, "_done"}, bus.done, 1'b1);
    check({label, "_busy"}, bus.busy, 1'b0);
  endtask

  task automatic end_check(input string label, input int strobes);
    check({label, "_queue_drained"}, exp_q.size(), 0);
    check({label, "_strobe_count"}, n_strobes, strobes);
    n_strobes = 0;
  endtask

  task automatic check_reset(input string label);
    check({label, "_flash_en"}, bus.flash_en, 1'b0);
    check({label, "_flash_addr"}, bus.flash_addr, 0);
    check({label, "_flash_data"}, bus.flash_data, 0);
    check({label, "_busy"}, bus.busy, 1'b1);
    check({label, "_done"}, bus.done, 1'b0);
    check({label, "_frame_err"}, bus.frame_err, 1'b0);
    check({label, "_hdr_err"}, bus.hdr_err, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    bus.rx = 1'b1;
    bus.start = 1'b0;
    tick(3);
    check_reset("reset");
    rst = 1'b0;
    tick(4);

    // Two-word image, then junk bytes in DONE that must be ignored
    push_exp(0, 32'h1234_5678, 1'b0);
    push_exp(1, 32'hDEAD_BEEF, 1'b1);
    bq = {8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_all(bq);
    wait_done("two_words");
    bq = {8'h01, 8'h00};
    send_all(bq);
    end_check("two_words", 2);

    // Empty image
    pulse_start();
    check("restart_busy", bus.busy, 1'b1);
    check("restart_done", bus.done, 1'b0);
    bq = {8'h00, 8'h00};
    send_all(bq);
    wait_done("empty");
    end_check("empty", 0);

    // Oversized header, then a valid image with the sticky error still set
    pulse_start();
    bq = {8'h01, 8'h08};
    send_all(bq);
    wait_done("oversize");
    check("oversize_hdr_err", bus.hdr_err, 1'b1);
    end_check("oversize", 0);
    pulse_start();
    push_exp(0, 32'hDDCC_BBAA, 1'b1);
    bq = {8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_all(bq);
    wait_done("after_hdr_err");
    check("hdr_err_sticky", bus.hdr_err, 1'b1);
    end_check("after_hdr_err", 1);

    // One-clock glitch must not produce a byte
    pulse_start();
    bus.rx = 1'b0;
    tick(1);
    bus.rx = 1'b1;
    tick(4 * CLKS);
    push_exp(0, 32'hA1B2_C3D4, 1'b1);
    bq = {8'h01, 8'h00, 8'hD4, 8'hC3, 8'hB2, 8'hA1};
    send_all(bq);
    wait_done("glitch");
    end_check("glitch", 1);

    // Framing error mid-word: bad byte dropped, next byte fills the same lane
    pulse_start();
    check("frame_err_clear_before", bus.frame_err, 1'b0);
    push_exp(0, 32'h5544_3311, 1'b1);
    bq = {8'h01, 8'h00, 8'h11};
    send_all(bq);
    send_byte(8'h22, 1'b0);
    bq = {8'h33, 8'h44, 8'h55};
    send_all(bq);
    wait_done("frame");
    check("frame_err_set", bus.frame_err, 1'b1);
    end_check("frame", 1);

    // Reset mid-frame, then a fresh load
    pulse_start();
    bq = {8'h02, 8'h00, 8'hAA, 8'h55};
    send_all(bq);
    bus.rx = 1'b0;
    tick(CLKS);
    bus.rx = 1'b1;
    tick(2 * CLKS);
    rst = 1'b1;
    tick(1);
    check_reset("mid_rst");
    tick(2);
    rst = 1'b0;
    bus.rx = 1'b1;
    exp_q.delete();
    tick(3 * CLKS);
    check_reset("post_rst");
    n_strobes = 0;
    push_exp(0, 32'h0403_0201, 1'b1);
    bq = {8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    send_all(bq);
    wait_done("fresh");
    end_check("fresh", 1);

    // Randomised images checked against the model
    for (int r = 0; r < 4; r++) begin
      int cnt;
      pulse_start();
      cnt = $urandom_range(1, 4);
      bq = {8'(cnt), 8'h00};
      for (int j = 0; j < 4 * cnt; j++) bq.push_back(8'($urandom));
      model_image(bq);
      send_all(bq);
      wait_done("random");
      send_byte(8'($urandom), 1'b1);
      check("random_hdr_err", bus.hdr_err, 1'b0);
      end_check("random", cnt);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_flash_loader.md
Name: uart_flash_loader

Overview:
Serial boot loader that sits directly upstream of the data/instruction memory's flash port. It receives a program image over a UART RX line, assembles little-endian 32-bit words, and drives flash_en/flash_addr/flash_data one word per pulse. It holds the core in reset via busy until the image is complete.

Parameters:
WIDTH, 32, data word width; must be 32 (4 bytes per word)
CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); minimum 4
ADDR_W, 11, flash word-address width; maximum image is 2**ADDR_W words

Ports:
clk  in  1  system clock; the only clock
rst  in  1  reset, asynchronous, active-high
rx  in  1  UART receive line; idle high; 8N1, LSB first
start  in  1  single-cycle pulse; re-arms the loader from DONE only
flash_en  out  1  one-cycle write strobe to memory flash port
flash_addr  out  ADDR_W  word address of the current write
flash_data  out  WIDTH  assembled word
busy  out  1  high while loading; gates core reset
done  out  1  image complete; cleared only by start or rst
frame_err  out  1  sticky; a byte had stop bit = 0
hdr_err  out  1  sticky; header word count exceeded 2**ADDR_W

Behaviour:
- Reset values: flash_en 0, flash_addr 0, flash_data 0, busy 1, done 0, frame_err 0, hdr_err 0. State is HDR0. Byte counters and word counters are 0.
- rx passes through a 2-flop synchronizer, reset value 1. All sampling uses the synchronized signal.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on a synchronized falling edge.
  - START: wait CLKS_PER_BIT/2 (integer divide), then sample. If the sample is high, treat it as a glitch and return to IDLE with no byte. If low, go to DATA.
  - DATA: sample 8 bits at intervals of CLKS_PER_BIT, LSB first.
  - STOP: sample after CLKS_PER_BIT. If high, raise byte_valid for 1 cycle. If low, set frame_err, discard the byte, and raise no strobe. Return to IDLE in both cases.
- Loader FSM states: HDR0, HDR1, LOAD, DONE. Each state advances only on byte_valid.
  - HDR0 latches count[7:0]. HDR1 latches count[15:8].
  - At the end of HDR1: if count == 0, go to DONE. If count > 2**ADDR_W, set hdr_err and go to DONE with no writes. Otherwise go to LOAD.
  - LOAD: byte k of each word lands in bits [8k+7:8k] (k = 0..3, little-endian).
  - On the 4th byte's byte_valid: in the next cycle flash_en = 1, flash_data = the word, flash_addr = the word index, starting at 0. The word index increments after the strobe.
  - flash_en is never high for two consecutive cycles. flash_addr and flash_data hold their values between strobes.
  - After the strobe for word count-1, go to DONE. done = 1 and busy = 0 starting the cycle after that final strobe. The address does not wrap, because count ≤ 2**ADDR_W.
- In DONE, further rx bytes are ignored.
- start in DONE: go to HDR0, busy = 1, done = 0, and clear the counters and the partial word. frame_err and hdr_err are not cleared. start in any other state is ignored.
- A framing error mid-word does not advance the byte counter. The next good byte fills the same lane.
- rst asserted at any time returns every register to its reset value immediately, including partial words and RX FSM state.

Test Plan:
- CLKS_PER_BIT=4. Send header 02 00, then 78 56 34 12 EF BE AD DE -> flash_en pulses with addr 0 / 0x12345678, then addr 1 / 0xDEADBEEF. The following cycle done=1, busy=0. Exactly 2 strobes total.
- Send header 00 00 -> done=1, busy=0 one cycle after the 2nd header byte_valid. No flash_en.
- Send header 01 08 (count 0x0801 with ADDR_W=11) -> hdr_err=1, done=1, no flash_en. Then pulse start and send 01 00 AA BB CC DD -> addr 0 / 0xDDCCBBAA, hdr_err stays 1.
- Send a 1-clk low glitch on rx, then header 01 00 and 4 bytes -> no spurious byte. A single strobe occurs at addr 0.
- Send header 01 00 and bytes 11, then 22 with stop bit 0, then 33 44 55 -> frame_err=1 and flash_data=0x55443311.
- Send header 02 00 and 2 data bytes, then assert rst for 3 cycles mid-frame -> all outputs are at reset values. A fresh load 01 00 01 02 03 04 writes addr 0 / 0x04030201.
